// File: rtl/matrix_ldst_unit_pkg.sv
// Shared types for the matrix load/store unit: op encodings, FSM states, default geometry.
// Pure declarations; no latency or flow-control behaviour of its own.
// Consumers import with matrix_ldst_unit_pkg::*.
package matrix_ldst_unit_pkg;

    localparam int DEF_MAT_DIM = 4;
    localparam int DEF_ELEM_W  = 16;
    localparam int DEF_WORD_W  = 32;
    localparam int DEF_MREG_W  = 4;
    localparam int DEF_ROW_W   = DEF_MAT_DIM * DEF_ELEM_W;

    typedef logic [DEF_ROW_W-1:0] matrix_row_t;

    typedef enum logic [1:0] {
        MNONE  = 2'd0,
        MLOAD  = 2'd1,
        MSTORE = 2'd2
    } m_mem_type_t;

    typedef enum logic [2:0] {
        IDLE,
        LD_REQ,
        LD_WB,
        ST_REQ,
        DONE
    } mldst_state_t;

    function automatic logic [31:0] sext_imm(input logic [10:0] imm);
        return {{21{imm[10]}}, imm};
    endfunction

endpackage

// File: rtl/matrix_ldst_unit_addr_gen.sv
// Word address generator: eff_base + running row offset + 4*word index.
// Zero latency from state to addr; registers advance on word_adv/row_adv strobes.
// No backpressure of its own; the parent only advances when dmem_ready completes a word.
module matrix_ldst_unit_addr_gen #(
    parameter int ROW_WORDS = 2,
    parameter int WW        = 1
) (
    input  logic          CLK,
    input  logic          nRST,
    input  logic          start,
    input  logic [31:0]   base,
    input  logic [31:0]   stride,
    input  logic          word_adv,
    input  logic          row_adv,
    output logic [31:0]   addr,
    output logic [WW-1:0] word_idx,
    output logic          last_word
);

    logic [31:0] base_q;
    logic [31:0] stride_q;
    logic [31:0] row_off_q;

    assign last_word = (word_idx == WW'(ROW_WORDS - 1));
    assign addr      = base_q + row_off_q + (32'(word_idx) << 2);

    // Row offset is accumulated rather than multiplied; wraps naturally mod 2^32.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            base_q    <= '0;
            stride_q  <= '0;
            row_off_q <= '0;
            word_idx  <= '0;
        end else if (start) begin
            base_q    <= base;
            stride_q  <= stride;
            row_off_q <= '0;
            word_idx  <= '0;
        end else begin
            if (word_adv)
                word_idx <= last_word ? '0 : word_idx + 1'b1;
            if (row_adv)
                row_off_q <= row_off_q + stride_q;
        end
    end

endmodule

// File: rtl/matrix_ldst_unit.sv
// Sequences ld.m/st.m as row-by-row word accesses between dmem and the matrix register file.
// Latency: load MAT_DIM*(ROW_WORDS+1)+1 cycles, store MAT_DIM*ROW_WORDS+1, with dmem_ready high.
// Backpressure: req_ready only in IDLE; each dmem access is held stable until dmem_ready.
module matrix_ldst_unit
    import matrix_ldst_unit_pkg::*;
#(
    parameter int MAT_DIM = DEF_MAT_DIM,
    parameter int ELEM_W  = DEF_ELEM_W,
    parameter int WORD_W  = DEF_WORD_W,
    parameter int MREG_W  = DEF_MREG_W,
    localparam int ROW_W     = MAT_DIM * ELEM_W,
    localparam int ROW_WORDS = ROW_W / WORD_W,
    localparam int RW        = $clog2(MAT_DIM),
    localparam int WW        = (ROW_WORDS > 1) ? $clog2(ROW_WORDS) : 1
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_mem_type,
    input  logic [MREG_W-1:0] req_md,
    input  logic [31:0]       req_base,
    input  logic [10:0]       req_imm,
    input  logic [31:0]       req_stride,
    output logic              mrf_wen,
    output logic [MREG_W-1:0] mrf_waddr,
    output logic [RW-1:0]     mrf_wrow,
    output logic [ROW_W-1:0]  mrf_wdata,
    output logic [MREG_W-1:0] mrf_raddr,
    output logic [RW-1:0]     mrf_rrow,
    input  logic [ROW_W-1:0]  mrf_rdata,
    output logic              dmem_ren,
    output logic              dmem_wen,
    output logic [31:0]       dmem_addr,
    output logic [WORD_W-1:0] dmem_store,
    input  logic [WORD_W-1:0] dmem_load,
    input  logic              dmem_ready,
    output logic              busy,
    output logic              done,
    output logic [MREG_W-1:0] done_md
);

    mldst_state_t      state_q, state_nxt;
    logic [MREG_W-1:0] md_q;
    logic [RW-1:0]     row_q;
    logic [ROW_W-1:0]  row_buf_q;
    logic [31:0]       gen_addr;
    logic [WW-1:0]     word_idx;
    logic              last_word;
    logic              last_row;
    logic              accept;
    logic              word_adv;
    logic              row_adv;

    assign accept   = req_valid && req_ready;
    assign last_row = (row_q == RW'(MAT_DIM - 1));
    assign word_adv = ((state_q == LD_REQ) || (state_q == ST_REQ)) && dmem_ready;
    assign row_adv  = (state_q == LD_WB) ||
                      ((state_q == ST_REQ) && dmem_ready && last_word);

    matrix_ldst_unit_addr_gen #(
        .ROW_WORDS (ROW_WORDS),
        .WW        (WW)
    ) u_addr_gen (
        .CLK       (CLK),
        .nRST      (nRST),
        .start     (accept),
        .base      (req_base + sext_imm(req_imm)),
        .stride    (req_stride),
        .word_adv  (word_adv),
        .row_adv   (row_adv),
        .addr      (gen_addr),
        .word_idx  (word_idx),
        .last_word (last_word)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            state_q <= IDLE;
        else
            state_q <= state_nxt;
    end

    always_comb begin
        state_nxt  = state_q;
        req_ready  = 1'b0;
        busy       = 1'b1;
        mrf_wen    = 1'b0;
        mrf_waddr  = '0;
        mrf_wrow   = '0;
        mrf_wdata  = '0;
        mrf_raddr  = '0;
        mrf_rrow   = '0;
        dmem_ren   = 1'b0;
        dmem_wen   = 1'b0;
        dmem_addr  = '0;
        dmem_store = '0;
        done       = 1'b0;
        done_md    = '0;
        unique case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                // MNONE is accepted but leaves the unit in IDLE.
                if (req_valid) begin
                    case (req_mem_type)
                        MLOAD:   state_nxt = LD_REQ;
                        MSTORE:  state_nxt = ST_REQ;
                        default: state_nxt = IDLE;
                    endcase
                end
            end
            LD_REQ: begin
                dmem_ren  = 1'b1;
                dmem_addr = gen_addr;
                if (dmem_ready && last_word)
                    state_nxt = LD_WB;
            end
            LD_WB: begin
                mrf_wen   = 1'b1;
                mrf_waddr = md_q;
                mrf_wrow  = row_q;
                mrf_wdata = row_buf_q;
                state_nxt = last_row ? DONE : LD_REQ;
            end
            ST_REQ: begin
                mrf_raddr  = md_q;
                mrf_rrow   = row_q;
                dmem_wen   = 1'b1;
                dmem_addr  = gen_addr;
                dmem_store = mrf_rdata[word_idx*WORD_W +: WORD_W];
                if (dmem_ready && last_word && last_row)
                    state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                done_md   = md_q;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            md_q      <= '0;
            row_q     <= '0;
            row_buf_q <= '0;
        end else begin
            if (accept) begin
                md_q  <= req_md;
                row_q <= '0;
            end else if (row_adv) begin
                row_q <= last_row ? '0 : row_q + 1'b1;
            end
            if ((state_q == LD_REQ) && dmem_ready)
                row_buf_q[word_idx*WORD_W +: WORD_W] <= dmem_load;
        end
    end

endmodule
